cpu_seq_ctrl: RTL and testbench



---
 rtl/cpu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer: owns the PC, fetches from a registered-read ROM, resolves
// JMP/JZ/HALT locally and hands other opcodes to the datapath. Optional watchdog: SEQ_WATCHDOG_EN.
module cpu_seq_ctrl #(
  parameter int WDOG_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       exec_valid,
  output logic [3:0] exec_op,
  output logic [3:0] exec_imm,
  input  logic       exec_ready,
  input  logic       zero_flag,
  output logic       busy,
  output logic       halted,
  output logic [7:0] instr_count,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [3:0] pc;
  logic [7:0] ir;

`ifdef SEQ_WATCHDOG_EN
  logic [3:0] stall;
  logic       fault_q;
`endif

  // NOTE: all state uses non-blocking assignments in one clocked block, so every
  // register updates from the same pre-edge values and the async reset clears all of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
`ifdef SEQ_WATCHDOG_EN
      stall       <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ir    <= rom_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (ir[7:4])
            OP_JMP: begin
              pc          <= ir[3:0];
              instr_count <= instr_count + 8'd1;
              state       <= S_FETCH;
            end
            OP_JZ: begin
              pc          <= zero_flag ? ir[3:0] : pc + 4'd1;
              instr_count <= instr_count + 8'd1;
              state       <= S_FETCH;
            end
            OP_HALT: begin
              instr_count <= instr_count + 8'd1;
              state       <= S_HALT;
            end
            default: begin
`ifdef SEQ_WATCHDOG_EN
              stall <= '0;
`endif
              state <= S_EXEC;
            end
          endcase
        end
        S_EXEC: begin
          if (exec_ready) begin
            pc          <= pc + 4'd1;
            instr_count <= instr_count + 8'd1;
            state       <= S_FETCH;
          end
`ifdef SEQ_WATCHDOG_EN
          // Abort on the stall cycle that brings the count up to the limit; pc stays put.
          else if (stall == 4'(WDOG_CYCLES - 1)) begin
            fault_q <= 1'b1;
            state   <= S_HALT;
          end else begin
            stall <= stall + 4'd1;
          end
`endif
        end
        S_HALT: begin
          if (start) begin
            pc    <= '0;
`ifdef SEQ_WATCHDOG_EN
            fault_q <= 1'b0;
`endif
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr   = pc;
  assign exec_valid = (state == S_EXEC);
  assign exec_op    = ir[7:4];
  assign exec_imm   = ir[3:0];
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);

`ifdef SEQ_WATCHDOG_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: registered ROM model plus a scoreboard of expected
// datapath handshakes (opcode, immediate, fetch address).
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       exec_valid;
  logic [3:0] exec_op;
  logic [3:0] exec_imm;
  logic       exec_ready;
  logic       zero_flag;
  logic       busy;
  logic       halted;
  logic [7:0] instr_count;
  logic       fault;

  cpu_seq_ctrl #(.WDOG_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .exec_valid(exec_valid), .exec_op(exec_op), .exec_imm(exec_imm),
    .exec_ready(exec_ready), .zero_flag(zero_flag), .busy(busy), .halted(halted),
    .instr_count(instr_count), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] pc;
  } xact_t;
  xact_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are judged at the falling edge, before the rising edge that accepts them.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && exec_valid === 1'b1 && exec_ready === 1'b1) begin
      check("sb_nonempty", 8'(sb_q.size() != 0), 8'd1);
      if (sb_q.size() != 0) begin
        xact_t e;
        e = sb_q.pop_front();
        check("sb_op", 8'(exec_op), 8'(e.op));
        check("sb_imm", 8'(exec_imm), 8'(e.imm));
        check("sb_pc", 8'(rom_addr), 8'(e.pc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in cycle 0; returns in cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; exec_ready = 1'b0; zero_flag = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
    tick(2);
    check("rst_valid", 8'(exec_valid), 8'd0);
    check("rst_addr", 8'(rom_addr), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_count", instr_count, 8'd0);
    check("rst_fault", 8'(fault), 8'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", 8'(busy), 8'd0);

    // ALU op then JMP back to 0.
    rom[0] = 8'h30; rom[1] = 8'hE0; exec_ready = 1'b1;
    sb_q.push_back('{op: 4'h3, imm: 4'h0, pc: 4'h0});
    pulse_start();
    check("t1_fetch_busy", 8'(busy), 8'd1);
    tick(2);
    check("t1_decode_valid", 8'(exec_valid), 8'd0);
    tick(1);
    check("t1_c4_valid", 8'(exec_valid), 8'd1);
    check("t1_c4_op", 8'(exec_op), 8'h3);
    check("t1_c4_imm", 8'(exec_imm), 8'h0);
    tick(1);
    check("t1_next_addr", 8'(rom_addr), 8'd1);
    tick(3);
    check("t1_jmp_addr", 8'(rom_addr), 8'd0);
    check("t1_count", instr_count, 8'd2);
    do_reset();

    // JZ taken / not taken.
    rom[0] = 8'hD5;
    zero_flag = 1'b1;
    pulse_start();
    tick(3);
    check("jz_set_addr", 8'(rom_addr), 8'd5);
    check("jz_count", instr_count, 8'd1);
    do_reset();
    zero_flag = 1'b0;
    pulse_start();
    tick(3);
    check("jz_clr_addr", 8'(rom_addr), 8'd1);
    do_reset();

    // Stalled handshake; start during EXEC is ignored.
    rom[0] = 8'h6B; exec_ready = 1'b0;
    sb_q.push_back('{op: 4'h6, imm: 4'hB, pc: 4'h0});
    pulse_start();
    tick(3);
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", 8'(exec_valid), 8'd1);
      check("stall_op", 8'(exec_op), 8'h6);
      check("stall_imm", 8'(exec_imm), 8'hB);
      if (i == 1) start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    check("stall_7_valid", 8'(exec_valid), 8'd1);
    exec_ready = 1'b1;
    tick(1);
    check("stall_after_addr", 8'(rom_addr), 8'd1);
    check("stall_after_valid", 8'(exec_valid), 8'd0);
    check("stall_count", instr_count, 8'd1);
    do_reset();

    // HALT and restart.
    rom[0] = 8'hF0;
    pulse_start();
    tick(3);
    check("halt_halted", 8'(halted), 8'd1);
    check("halt_busy", 8'(busy), 8'd0);
    check("halt_count", instr_count, 8'd1);
    tick(3);
    check("halt_stays", 8'(halted), 8'd1);
    rom[0] = 8'h30;
    sb_q.push_back('{op: 4'h3, imm: 4'h0, pc: 4'h0});
    pulse_start();
    check("restart_halted", 8'(halted), 8'd0);
    check("restart_busy", 8'(busy), 8'd1);
    check("restart_addr", 8'(rom_addr), 8'd0);
    tick(4);
    check("restart_next_addr", 8'(rom_addr), 8'd1);
    do_reset();

    // 16 ALU ops: PC wraps, then async reset while offering.
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h30;
      sb_q.push_back('{op: 4'h3, imm: 4'h0, pc: 4'(i)});
    end
    pulse_start();
    tick(64);
    check("wrap_addr", 8'(rom_addr), 8'd0);
    check("wrap_count", instr_count, 8'd16);
    exec_ready = 1'b0;
    tick(3);
    check("pre_rst_valid", 8'(exec_valid), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 8'(exec_valid), 8'd0);
    check("async_busy", 8'(busy), 8'd0);
    check("async_count", instr_count, 8'd0);
    check("async_op", 8'(exec_op), 8'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_idle", 8'(busy), 8'd0);

    // Long stall: watchdog abort when compiled in, indefinite wait otherwise.
    rom[0] = 8'h30; exec_ready = 1'b0;
    pulse_start();
    tick(3);
`ifdef SEQ_WATCHDOG_EN
    tick(14);
    check("wd_c15_valid", 8'(exec_valid), 8'd1);
    check("wd_c15_fault", 8'(fault), 8'd0);
    tick(1);
    check("wd_fault", 8'(fault), 8'd1);
    check("wd_halted", 8'(halted), 8'd1);
    check("wd_valid", 8'(exec_valid), 8'd0);
    check("wd_addr", 8'(rom_addr), 8'd0);
    pulse_start();
    check("wd_fault_clear", 8'(fault), 8'd0);
`else
    tick(20);
    check("nowd_valid", 8'(exec_valid), 8'd1);
    check("nowd_fault", 8'(fault), 8'd0);
`endif
    do_reset();

    check("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
